// File: rtl/memory_request_credit_scheduler_pkg.sv
// Shared types for the memory request credit scheduler: request packet,
// FSM state encoding and a small index-width helper.
package memory_request_credit_scheduler_pkg;

    localparam int unsigned MEM_ADDR_W = 32;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_TAG_W  = 8;

    // One memory request; valid doubles as the requester's request strobe.
    typedef struct packed {
        logic                  valid;
        logic                  write;
        logic [MEM_TAG_W-1:0]  tag;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] data;
    } MemoryPacketRequest;

    // IDLE: no owner. BURST: one owner issuing up to the burst limit.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } scheduler_state_e;

    // Index width for an n-entry vector, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/memory_request_credit_scheduler_rr_select.sv
// Round-robin priority select: one-hot of the first eligible index at or
// after the pointer, wrapping modulo WIDTH. All zero when nothing is eligible.
module round_robin_priority_select
    import memory_request_credit_scheduler_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned PW    = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] eligible,
    input  logic [PW-1:0]    pointer,
    output logic [WIDTH-1:0] grant_onehot
);

    logic          found;
    logic [PW-1:0] idx;

    // Walk the candidates starting at the pointer and keep the first hit.
    always_comb begin
        grant_onehot = '0;
        found        = 1'b0;
        idx          = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            idx = PW'((32'(pointer) + k) % WIDTH);
            if (!found && eligible[idx]) begin
                grant_onehot[idx] = 1'b1;
                found             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/memory_request_credit_scheduler.sv
// Memory request credit scheduler: round-robin burst arbitration across
// requesters, gated by per-requester outstanding-request credits, with one
// registered output slot.
// Optional per-requester acceptance counters: define MEMORY_SCHEDULER_STATS_EN.
module memory_request_credit_scheduler
    import memory_request_credit_scheduler_pkg::*;
#(
    parameter  int unsigned NUM_MEMORY_REQUESTOR = 4,
    parameter  int unsigned MAX_OUTSTANDING      = 8,
    parameter  int unsigned BURST_LIMIT          = 4,
    localparam int unsigned IDW = idx_width(NUM_MEMORY_REQUESTOR),
    localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1),
    localparam int unsigned BW  = $clog2(BURST_LIMIT + 1)
) (
    input  logic                                ap_clk,
    input  logic                                ap_rst_n,
    input  MemoryPacketRequest [NUM_MEMORY_REQUESTOR-1:0] request_in,
    output logic [NUM_MEMORY_REQUESTOR-1:0]     request_in_ready,
    output MemoryPacketRequest                  request_out,
    input  logic                                request_out_ready,
    input  logic                                response_in_valid,
    input  logic [IDW-1:0]                      response_in_id,
    output logic [NUM_MEMORY_REQUESTOR-1:0]     arbiter_grant_out,
    output logic                                scheduler_idle_out,
    output logic                                credit_error_out
`ifdef MEMORY_SCHEDULER_STATS_EN
    ,
    output logic [NUM_MEMORY_REQUESTOR-1:0][31:0] stats_issued_count_out
`endif
);

    localparam int unsigned N = NUM_MEMORY_REQUESTOR;

    scheduler_state_e   state_q, state_d;
    logic [IDW-1:0]     owner_q, owner_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]      burst_q, burst_d;
    logic [N-1:0]       grant_q, grant_d;
    logic [N-1:0][CW-1:0] credit_q, credit_d;
    MemoryPacketRequest out_q, out_d;
    logic               err_q, err_d;
    logic               idle_q, idle_d;

    logic [N-1:0]       eligible;
    logic [N-1:0]       sel_onehot;
    logic [IDW-1:0]     sel_idx;
    logic [N-1:0]       owner_onehot;
    logic [N-1:0]       accept_vec;
    logic [N-1:0]       resp_hit;
    logic [N-1:0]       resp_ok;
    logic               out_free;
    logic               owner_can_issue;
    logic               accept;
    logic               others_eligible;
    logic               owner_release;
    logic               all_full_d;
    logic [BW-1:0]      burst_nxt;
    logic [IDW-1:0]     owner_inc;

    // A requester competes only while it is requesting and holds a credit.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            eligible[i] = request_in[i].valid && (credit_q[i] != '0);
        end
    end

    round_robin_priority_select #(
        .WIDTH (N)
    ) u_rr_select (
        .eligible     (eligible),
        .pointer      (rr_ptr_q),
        .grant_onehot (sel_onehot)
    );

    // One-hot selection to owner index.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_onehot[i]) begin
                sel_idx = IDW'(i);
            end
        end
    end

    assign owner_onehot    = N'(1) << owner_q;
    assign out_free        = !out_q.valid || request_out_ready;
    assign owner_can_issue = ap_rst_n && (state_q == BURST) && (credit_q[owner_q] != '0)
                             && (burst_q < BW'(BURST_LIMIT)) && out_free;
    assign request_in_ready = owner_can_issue ? owner_onehot : '0;
    assign accept          = owner_can_issue && request_in[owner_q].valid;
    assign accept_vec      = accept ? owner_onehot : '0;
    assign burst_nxt       = burst_q + BW'(accept);
    assign others_eligible = |(eligible & ~owner_onehot);
    assign owner_inc       = (owner_q == IDW'(N - 1)) ? '0 : owner_q + IDW'(1);
    assign owner_release   = !eligible[owner_q] || (burst_nxt == BW'(BURST_LIMIT))
                             || (others_eligible && !accept);

    // Arbitration FSM next state: pick an owner in IDLE, count and release in BURST.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        burst_d  = burst_q;
        grant_d  = grant_q;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d = BURST;
                    owner_d = sel_idx;
                    burst_d = '0;
                    grant_d = sel_onehot;
                end
            end
            BURST: begin
                burst_d = burst_nxt;
                if (owner_release) begin
                    state_d  = IDLE;
                    rr_ptr_d = owner_inc;
                    burst_d  = '0;
                    grant_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Credit bookkeeping; a return into a full counter is only legal when the
    // same counter is being spent in this cycle.
    always_comb begin
        all_full_d = 1'b1;
        for (int i = 0; i < N; i++) begin
            resp_hit[i] = response_in_valid && (response_in_id == IDW'(i));
            resp_ok[i]  = resp_hit[i] && ((credit_q[i] != CW'(MAX_OUTSTANDING)) || accept_vec[i]);
            credit_d[i] = credit_q[i] - CW'(accept_vec[i]) + CW'(resp_ok[i]);
            if (credit_d[i] != CW'(MAX_OUTSTANDING)) begin
                all_full_d = 1'b0;
            end
        end
        err_d = err_q || (response_in_valid && !(|resp_ok));
    end

    // Output slot: load on acceptance, empty after a transfer, hold otherwise.
    always_comb begin
        out_d = out_q;
        if (out_free) begin
            if (accept) begin
                out_d = request_in[owner_q];
            end else begin
                out_d.valid = 1'b0;
            end
        end
    end

    assign idle_d = (state_d == IDLE) && !out_d.valid && all_full_d;

    // State, credit and output registers with synchronous reset.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_q     <= '0;
            grant_q     <= '0;
            credit_q    <= {N{CW'(MAX_OUTSTANDING)}};
            out_q.valid <= 1'b0;
            err_q       <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            burst_q  <= burst_d;
            grant_q  <= grant_d;
            credit_q <= credit_d;
            out_q    <= out_d;
            err_q    <= err_d;
            idle_q   <= idle_d;
        end
    end

    assign request_out        = out_q;
    assign arbiter_grant_out  = grant_q;
    assign scheduler_idle_out = idle_q;
    assign credit_error_out   = err_q;

`ifdef MEMORY_SCHEDULER_STATS_EN
    logic [N-1:0][31:0] stats_q;

    // Saturating per-requester acceptance counters.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            stats_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (accept_vec[i] && (stats_q[i] != '1)) begin
                    stats_q[i] <= stats_q[i] + 32'd1;
                end
            end
        end
    end

    assign stats_issued_count_out = stats_q;
`endif

endmodule
